control_decode_stage: RTL and testbench

//  Parametrised MIPS main-control decoder with registered ID/EX control stage. Decodes opcode
//  of the ID-stage instruction into an 11-bit control word, detects load-use hazards against
//  the load held in EX, inserts bubbles, honours pipeline hold/flush, and counts illegal opcodes.

---
 rtl/control_decode_stage.sv | 152 +++++++++++++++
 tb/tb_control_decode_stage.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/control_decode_stage.sv
// Main-control decoder with a registered ID/EX control stage: load-use bubble
// insertion, hold/flush handling and a saturating illegal-opcode counter.
module control_decode_stage #(
  parameter int CNT_W     = 8,
  parameter int HAZARD_EN = 1,
  parameter int JUMP_EN   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr_i,
  input  logic             instr_valid_i,
  input  logic             hold_i,
  input  logic             flush_i,
  output logic [10:0]      ctrl_o,
  output logic             ctrl_valid_o,
  output logic [4:0]       ex_wreg_o,
  output logic             ex_byte_o,
  output logic             stall_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] illegal_cnt_o
);

  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_J    = 6'd2;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_BNE  = 6'd5;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_LB   = 6'd32;
  localparam logic [5:0] OP_LW   = 6'd35;
  localparam logic [5:0] OP_SB   = 6'd40;
  localparam logic [5:0] OP_SW   = 6'd43;

  localparam logic [10:0] CW_R    = 11'h182;
  localparam logic [10:0] CW_J    = 11'h400;
  localparam logic [10:0] CW_BEQ  = 11'h050;
  localparam logic [10:0] CW_BNE  = 11'h250;
  localparam logic [10:0] CW_ADDI = 11'h0E2;
  localparam logic [10:0] CW_LOAD = 11'h02B;
  localparam logic [10:0] CW_STOR = 11'h024;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {ST_RUN, ST_BUBBLE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [10:0] dec_ctrl;
  logic        dec_legal, dec_byte, dec_jump, dec_uses_rt;
  logic [4:0]  dec_wreg;
  logic        haz_raw, haz;
  logic        load_dec, count_ill;
  logic        unused_bits;

  assign opcode      = instr_i[31:26];
  assign rs          = instr_i[25:21];
  assign rt          = instr_i[20:16];
  assign rd          = instr_i[15:11];
  assign unused_bits = ^instr_i[10:0];

  always_comb begin
    dec_ctrl    = 11'h000;
    dec_legal   = 1'b1;
    dec_byte    = 1'b0;
    dec_jump    = 1'b0;
    dec_uses_rt = 1'b0;
    case (opcode)
      OP_R:    begin dec_ctrl = CW_R;    dec_uses_rt = 1'b1; end
      OP_J: begin
        if (JUMP_EN != 0) begin
          dec_ctrl = CW_J;
          dec_jump = 1'b1;
        end else begin
          dec_legal = 1'b0;
        end
      end
      OP_BEQ:  begin dec_ctrl = CW_BEQ;  dec_uses_rt = 1'b1; end
      OP_BNE:  begin dec_ctrl = CW_BNE;  dec_uses_rt = 1'b1; end
      OP_ADDI: dec_ctrl = CW_ADDI;
      OP_LB:   begin dec_ctrl = CW_LOAD; dec_byte = 1'b1; end
      OP_LW:   dec_ctrl = CW_LOAD;
      OP_SB:   begin dec_ctrl = CW_STOR; dec_byte = 1'b1; dec_uses_rt = 1'b1; end
      OP_SW:   begin dec_ctrl = CW_STOR; dec_uses_rt = 1'b1; end
      default: dec_legal = 1'b0;
    endcase
  end

  assign dec_wreg = dec_ctrl[8] ? rd : rt;

  // Only a load sitting in EX can create a load-use hazard; $0 never does.
  assign haz_raw = ctrl_valid_o & ctrl_o[3] & (ex_wreg_o != 5'd0) & instr_valid_i &
                   (((ex_wreg_o == rs) & ~dec_jump) | ((ex_wreg_o == rt) & dec_uses_rt));
  assign haz     = (HAZARD_EN != 0) & haz_raw;
  assign stall_o = haz & ~flush_i;

  always_comb begin
    state_d   = state_q;
    load_dec  = 1'b0;
    count_ill = 1'b0;
    if (!hold_i) begin
      state_d = ST_RUN;
      if (flush_i) begin
        load_dec = 1'b0;
      end else if (stall_o && state_q == ST_RUN) begin
        state_d = ST_BUBBLE;
      end else if (instr_valid_i && dec_legal) begin
        load_dec = 1'b1;
      end else if (instr_valid_i) begin
        count_ill = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Anything that is not a normal legal load becomes a bubble in EX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_o        <= 11'h000;
      ctrl_valid_o  <= 1'b0;
      ex_wreg_o     <= 5'd0;
      ex_byte_o     <= 1'b0;
      illegal_o     <= 1'b0;
      illegal_cnt_o <= '0;
    end else if (hold_i) begin
      illegal_o <= 1'b0;
    end else begin
      illegal_o <= count_ill;
      if (load_dec) begin
        ctrl_o       <= dec_ctrl;
        ctrl_valid_o <= 1'b1;
        ex_wreg_o    <= dec_wreg;
        ex_byte_o    <= dec_byte;
      end else begin
        ctrl_o       <= 11'h000;
        ctrl_valid_o <= 1'b0;
        ex_wreg_o    <= 5'd0;
        ex_byte_o    <= 1'b0;
      end
      if (count_ill && illegal_cnt_o != CNT_MAX) begin
        illegal_cnt_o <= illegal_cnt_o + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_control_decode_stage.sv
// Randomised bench for control_decode_stage: three parameterisations share stimulus
// and are compared each cycle against an instruction-level reference model.
module tb_control_decode_stage;

  localparam int CW [3] = '{8, 2, 8};
  localparam int HE [3] = '{1, 1, 0};
  localparam int JE [3] = '{1, 1, 0};

  localparam logic [31:0] I_ADD  = 32'h012A4020; // add $8,$9,$10
  localparam logic [31:0] I_LW   = 32'h8D280000; // lw  $8,0($9)
  localparam logic [31:0] I_ADD2 = 32'h010B5020; // add $10,$8,$11
  localparam logic [31:0] I_SW   = 32'hAD280000; // sw  $8,0($9)
  localparam logic [31:0] I_ILL  = 32'hFC000000; // opcode 0x3F

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        ivalid, hold, flush;

  logic [10:0] d_ctrl  [3];
  logic        d_valid [3];
  logic [4:0]  d_wreg  [3];
  logic        d_byte  [3];
  logic        d_stall [3];
  logic        d_ill   [3];
  logic [7:0]  cnt0, cnt2;
  logic [1:0]  cnt1;

  logic [10:0] m_ctrl  [3];
  logic        m_valid [3];
  logic [4:0]  m_wreg  [3];
  logic        m_byte  [3];
  logic        m_ill   [3];
  int          m_cnt   [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  control_decode_stage u0 (
    .clk(clk), .rst(rst), .instr_i(instr), .instr_valid_i(ivalid), .hold_i(hold), .flush_i(flush),
    .ctrl_o(d_ctrl[0]), .ctrl_valid_o(d_valid[0]), .ex_wreg_o(d_wreg[0]), .ex_byte_o(d_byte[0]),
    .stall_o(d_stall[0]), .illegal_o(d_ill[0]), .illegal_cnt_o(cnt0));

  control_decode_stage #(.CNT_W(2)) u1 (
    .clk(clk), .rst(rst), .instr_i(instr), .instr_valid_i(ivalid), .hold_i(hold), .flush_i(flush),
    .ctrl_o(d_ctrl[1]), .ctrl_valid_o(d_valid[1]), .ex_wreg_o(d_wreg[1]), .ex_byte_o(d_byte[1]),
    .stall_o(d_stall[1]), .illegal_o(d_ill[1]), .illegal_cnt_o(cnt1));

  control_decode_stage #(.HAZARD_EN(0), .JUMP_EN(0)) u2 (
    .clk(clk), .rst(rst), .instr_i(instr), .instr_valid_i(ivalid), .hold_i(hold), .flush_i(flush),
    .ctrl_o(d_ctrl[2]), .ctrl_valid_o(d_valid[2]), .ex_wreg_o(d_wreg[2]), .ex_byte_o(d_byte[2]),
    .stall_o(d_stall[2]), .illegal_o(d_ill[2]), .illegal_cnt_o(cnt2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Instruction-set view: opcode -> control word and operand usage.
  function automatic void decode(input logic [5:0] op, input int je, output logic [10:0] c,
                                 output logic legal, output logic byt, output logic is_j,
                                 output logic uses_rt);
    c = 11'h000; legal = 1'b1; byt = 1'b0; is_j = 1'b0; uses_rt = 1'b0;
    case (op)
      6'd0:  begin c = 11'h182; uses_rt = 1'b1; end
      6'd2:  if (je != 0) begin c = 11'h400; is_j = 1'b1; end else legal = 1'b0;
      6'd4:  begin c = 11'h050; uses_rt = 1'b1; end
      6'd5:  begin c = 11'h250; uses_rt = 1'b1; end
      6'd8:  c = 11'h0E2;
      6'd32: begin c = 11'h02B; byt = 1'b1; end
      6'd35: c = 11'h02B;
      6'd40: begin c = 11'h024; byt = 1'b1; uses_rt = 1'b1; end
      6'd43: begin c = 11'h024; uses_rt = 1'b1; end
      default: legal = 1'b0;
    endcase
  endfunction

  function automatic logic model_stall(input int k);
    logic [10:0] c;
    logic legal, byt, is_j, urt, ex_is_load, dep;
    decode(instr[31:26], JE[k], c, legal, byt, is_j, urt);
    ex_is_load = m_valid[k] && m_ctrl[k][3] && m_wreg[k] != 5'd0;
    dep = (!is_j && m_wreg[k] == instr[25:21]) || (urt && m_wreg[k] == instr[20:16]);
    return (HE[k] != 0) && ex_is_load && ivalid && dep && !flush;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_ctrl[k] = 11'h000; m_valid[k] = 1'b0; m_wreg[k] = 5'd0;
      m_byte[k] = 1'b0; m_ill[k] = 1'b0; m_cnt[k] = 0;
    end
  endtask

  task automatic model_edge(input int k);
    logic [10:0] c;
    logic legal, byt, is_j, urt, st;
    decode(instr[31:26], JE[k], c, legal, byt, is_j, urt);
    st = model_stall(k);
    m_ill[k] = 1'b0;
    if (!hold) begin
      if (flush || st || !ivalid || !legal) begin
        m_ctrl[k] = 11'h000; m_valid[k] = 1'b0; m_wreg[k] = 5'd0; m_byte[k] = 1'b0;
        if (!flush && !st && ivalid) begin
          m_ill[k] = 1'b1;
          if (m_cnt[k] < (1 << CW[k]) - 1) m_cnt[k]++;
        end
      end else begin
        m_ctrl[k] = c; m_valid[k] = 1'b1; m_byte[k] = byt;
        m_wreg[k] = c[8] ? instr[15:11] : instr[20:16];
      end
    end
  endtask

  function automatic logic [31:0] get_cnt(input int k);
    case (k)
      0:       return {24'd0, cnt0};
      1:       return {30'd0, cnt1};
      default: return {24'd0, cnt2};
    endcase
  endfunction

  task automatic check_all(input string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s.u%0d.ctrl", tag, k), {21'd0, d_ctrl[k]}, {21'd0, m_ctrl[k]});
      check($sformatf("%s.u%0d.valid", tag, k), {31'd0, d_valid[k]}, {31'd0, m_valid[k]});
      check($sformatf("%s.u%0d.wreg", tag, k), {27'd0, d_wreg[k]}, {27'd0, m_wreg[k]});
      check($sformatf("%s.u%0d.byte", tag, k), {31'd0, d_byte[k]}, {31'd0, m_byte[k]});
      check($sformatf("%s.u%0d.stall", tag, k), {31'd0, d_stall[k]}, {31'd0, model_stall(k)});
      check($sformatf("%s.u%0d.ill", tag, k), {31'd0, d_ill[k]}, {31'd0, m_ill[k]});
      check($sformatf("%s.u%0d.cnt", tag, k), get_cnt(k), m_cnt[k]);
    end
  endtask

  // Drive one cycle: inputs just after posedge, check at negedge, advance model at posedge.
  task automatic step(input string tag, input logic [31:0] in, input logic v,
                      input logic h, input logic f);
    instr = in; ivalid = v; hold = h; flush = f;
    @(negedge clk);
    check_all(tag);
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_edge(k);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] op;
    logic [31:0] r;
    case ($urandom_range(0, 11))
      0, 1:    op = 6'd35;
      2:       op = 6'd32;
      3:       op = 6'd0;
      4:       op = 6'd2;
      5:       op = 6'd4;
      6:       op = 6'd5;
      7:       op = 6'd8;
      8:       op = 6'd40;
      9:       op = 6'd43;
      default: op = 6'($urandom_range(0, 63));
    endcase
    r = $urandom;
    return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), r[10:0]};
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; instr = 32'd0; ivalid = 1'b0; hold = 1'b0; flush = 1'b0;
    model_reset();
    #2;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_edge(k);
    #1;

    step("t1a", I_ADD, 1'b1, 1'b0, 1'b0);
    check("t1.ctrl", {21'd0, d_ctrl[0]}, 32'h182);
    check("t1.wreg", {27'd0, d_wreg[0]}, 32'd8);

    step("t2a", I_LW, 1'b1, 1'b0, 1'b0);
    instr = I_ADD2; ivalid = 1'b1; #1;
    check("t2.stall", {31'd0, d_stall[0]}, 32'd1);
    check("t2.nohaz_stall", {31'd0, d_stall[2]}, 32'd0);
    step("t2b", I_ADD2, 1'b1, 1'b0, 1'b0);
    check("t2.bubble_valid", {31'd0, d_valid[0]}, 32'd0);
    check("t2.nohaz_ctrl", {21'd0, d_ctrl[2]}, 32'h182);
    step("t2c", I_ADD2, 1'b1, 1'b0, 1'b0);
    check("t2.ctrl", {21'd0, d_ctrl[0]}, 32'h182);
    check("t2.wreg", {27'd0, d_wreg[0]}, 32'd10);

    step("t3a", I_LW, 1'b1, 1'b0, 1'b0);
    instr = I_SW; ivalid = 1'b1; flush = 1'b1; #1;
    check("t3.stall", {31'd0, d_stall[0]}, 32'd0);
    step("t3b", I_SW, 1'b1, 1'b0, 1'b1);
    check("t3.valid", {31'd0, d_valid[0]}, 32'd0);

    step("t4a", I_ADD, 1'b1, 1'b0, 1'b0);
    step("t4b", I_ILL, 1'b1, 1'b1, 1'b0);
    step("t4c", I_LW, 1'b1, 1'b1, 1'b1);
    step("t4d", I_ILL, 1'b0, 1'b1, 1'b0);
    check("t4.ctrl", {21'd0, d_ctrl[0]}, 32'h182);
    check("t4.cnt", get_cnt(0), 32'd0);

    for (int i = 0; i < 5; i++) begin
      step("t5", I_ILL, 1'b1, 1'b0, 1'b0);
      check("t5.pulse", {31'd0, d_ill[1]}, 32'd1);
      check("t5.cnt", get_cnt(1), (i < 3) ? i + 1 : 3);
    end

    step("t6a", I_LW, 1'b1, 1'b0, 1'b0);
    step("t6b", I_ADD2, 1'b1, 1'b0, 1'b0);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check_all("t6.rst");
    @(negedge clk);
    rst = 1'b0;
    instr = 32'd0; ivalid = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_edge(k);
    #1;
    step("t6c", I_ADD, 1'b1, 1'b0, 1'b0);
    check("t6.ctrl", {21'd0, d_ctrl[0]}, 32'h182);

    for (int i = 0; i < 3000; i++) begin
      step("rnd", rand_instr(), $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 15,
           $urandom_range(0, 99) < 10);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
